// File: rtl/wb_sdram_wbuf_pkg.sv
// wb_sdram_wbuf_pkg: shared FSM encoding, cycle-type constant and FIFO entry width
package wb_sdram_wbuf_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_RACK, ST_GAP} state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    // One buffered write: {addr, data, byte selects}
    function automatic int entry_w(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

endpackage

// File: rtl/wb_sdram_wbuf_if.sv
// wb_sdram_wbuf_if: classic Wishbone bus bundle
//   master modport: drives cyc/stb/we/addr/dat_w/sel/cti, receives ack/dat_r
//   slave modport : the mirror image
interface wb_sdram_wbuf_if #(parameter int AW = 26, parameter int DW = 32);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_w;
    logic [DW/8-1:0] sel;
    logic [2:0]    cti;
    logic          ack;
    logic [DW-1:0] dat_r;

    modport master(output cyc, stb, we, addr, dat_w, sel, cti, input ack, dat_r);
    modport slave(input cyc, stb, we, addr, dat_w, sel, cti, output ack, dat_r);
endinterface

// File: rtl/wb_sdram_wbuf_fifo.sv
// wbuf_fifo: register-based synchronous FIFO with occupancy counter
//   clk_i/rst_i    : clock, synchronous active-high reset
//   push_i/din_i   : write an entry (caller guarantees not full)
//   pop_i/dout_o   : head entry, removed on pop (caller guarantees not empty)
//   level_o        : occupied entries; empty_o/full_o derived from it
module wbuf_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [W-1:0]        din_i,
    input  logic                pop_i,
    output logic [W-1:0]        dout_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                empty_o,
    output logic                full_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_q;
    logic [DEPTH_LOG2-1:0]   rd_q;
    logic [LW-1:0]           level_q;

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    // Pointers wrap naturally; full/empty come only from the level counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= push_i ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop_i ? rd_q + 1'b1 : rd_q;
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign level_o = level_q;
    assign empty_o = level_q == '0;
    assign full_o  = level_q == LW'(DEPTH);
endmodule

// File: rtl/wb_sdram_wbuf.sv
// wb_sdram_wbuf: posted-write buffer between a CPU Wishbone bus and the SDRAM controller
//   wb_clk_i/wb_rst_i : single clock, synchronous active-high reset
//   cpu               : CPU-side slave bus (writes acked at once while space remains)
//   mem               : master bus to the SDRAM controller, single classic cycles
//   sdr_init_done     : master side stays idle while low
//   buf_level/buf_empty : write FIFO occupancy
module wb_sdram_wbuf
    import wb_sdram_wbuf_pkg::*;
#(
    parameter int AW         = 26,
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_sdram_wbuf_if.slave        cpu,
    wb_sdram_wbuf_if.master       mem,
    input  logic                  sdr_init_done,
    output logic [DEPTH_LOG2:0]   buf_level,
    output logic                  buf_empty
);
    localparam int EW = entry_w(AW, DW);

    state_e          state_q;
    logic            ack_q;
    logic [DW-1:0]   rdat_q;
    logic            m_cyc_q;
    logic            m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_dat_q;
    logic [DW/8-1:0] m_sel_q;

    logic            req;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_go;
    logic            rd_go;
    logic            ack_d;
    logic [EW-1:0]   head;

    // Masking with the outgoing ack stops the held strobe from being taken twice
    assign req   = cpu.cyc & cpu.stb & ~ack_q;
    assign push  = req & cpu.we & ~full;
    assign pop   = (state_q == ST_WR) & mem.ack;
    assign wr_go = (state_q == ST_IDLE) & ~buf_empty & sdr_init_done;
    // Reads only start with the FIFO empty, so they can never overtake a write
    assign rd_go = (state_q == ST_IDLE) & req & ~cpu.we & buf_empty & sdr_init_done;
    assign ack_d = push | ((state_q == ST_RD) & mem.ack);

    wbuf_fifo #(.W(EW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .din_i   ({cpu.addr, cpu.dat_w, cpu.sel}),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (buf_level),
        .empty_o (buf_empty),
        .full_o  (full)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            m_cyc_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            m_dat_q  <= '0;
            m_sel_q  <= '0;
        end else begin
            ack_q <= ack_d;
            case (state_q)
                ST_IDLE: begin
                    if (wr_go) begin
                        state_q                        <= ST_WR;
                        m_cyc_q                        <= 1'b1;
                        m_we_q                         <= 1'b1;
                        {m_addr_q, m_dat_q, m_sel_q}   <= head;
                    end else if (rd_go) begin
                        state_q  <= ST_RD;
                        m_cyc_q  <= 1'b1;
                        m_we_q   <= 1'b0;
                        m_addr_q <= cpu.addr;
                        m_sel_q  <= cpu.sel;
                    end
                end
                ST_WR: begin
                    if (mem.ack) begin
                        state_q <= ST_GAP;
                        m_cyc_q <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (mem.ack) begin
                        state_q <= ST_RACK;
                        m_cyc_q <= 1'b0;
                        rdat_q  <= mem.dat_r;
                    end
                end
                // ack_q is high during RACK, set on the RD exit
                ST_RACK: state_q <= ST_GAP;
                // One dead cycle so the controller sees separate transactions
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu.ack   = ack_q;
    assign cpu.dat_r = rdat_q;
    assign mem.cyc   = m_cyc_q;
    assign mem.stb   = m_cyc_q;
    assign mem.we    = m_we_q;
    assign mem.addr  = m_addr_q;
    assign mem.dat_w = m_dat_q;
    assign mem.sel   = m_sel_q;
    assign mem.cti   = CTI_CLASSIC;
endmodule

// File: tb/tb_wb_sdram_wbuf.sv
// tb_wb_sdram_wbuf: scoreboard bench for the posted-write buffer
module tb_wb_sdram_wbuf;
    import wb_sdram_wbuf_pkg::*;

    typedef struct {
        logic        we;
        logic [25:0] addr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init = 1'b0;
    logic [2:0]  buf_level;
    logic        buf_empty;
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 0;
    logic [31:0] mem_rdata = '0;
    txn_t        exp_q[$];
    txn_t        mon_e;
    logic        mon_abort;
    int          lat;
    int          lat5;
    logic [31:0] rd;

    always #5 clk = ~clk;

    wb_sdram_wbuf_if #(.AW(26), .DW(32)) cpu ();
    wb_sdram_wbuf_if #(.AW(26), .DW(32)) mem ();

    wb_sdram_wbuf #(.AW(26), .DW(32), .DEPTH_LOG2(2)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cpu           (cpu),
        .mem           (mem),
        .sdr_init_done (init),
        .buf_level     (buf_level),
        .buf_empty     (buf_empty)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Classic master: hold the strobe through the ack cycle, release after the next edge
    task automatic cpu_write(input logic [25:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int l);
        exp_q.push_back('{1'b1, a, d, s});
        cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b1;
        cpu.addr = a; cpu.dat_w = d; cpu.sel = s;
        l = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (cpu.ack) begin l = i; break; end
        end
        if (l < 0) chk("wr_timeout", 1, 0);
        @(posedge clk); #1;
        cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
    endtask

    task automatic cpu_read(input logic [25:0] a, input logic [3:0] s,
                            output logic [31:0] d, output int l);
        exp_q.push_back('{1'b0, a, 32'h0, s});
        cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b0;
        cpu.addr = a; cpu.sel = s;
        l = -1;
        d = '0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (cpu.ack) begin l = i; d = cpu.dat_r; break; end
        end
        if (l < 0) chk("rd_timeout", 1, 0);
        @(posedge clk); #1;
        cpu.cyc = 1'b0; cpu.stb = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 500 && (exp_q.size() != 0 || !buf_empty || mem.cyc); n++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_empty"}, buf_empty, 1);
        chk({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    // SDRAM controller model: checks each master cycle against the scoreboard,
    // acks ack_delay cycles after the strobe appears, then checks drop and gap
    initial begin
        mem.ack = 1'b0;
        mem.dat_r = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && mem.cyc && mem.stb) begin
                mon_abort = 1'b0;
                chk("m_cti", mem.cti, CTI_CLASSIC);
                if (exp_q.size() == 0) chk("m_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("m_we", mem.we, mon_e.we);
                    chk("m_addr", mem.addr, mon_e.addr);
                    chk("m_sel", mem.sel, mon_e.sel);
                    if (mon_e.we) chk("m_dat", mem.dat_w, mon_e.dat);
                end
                for (int i = 0; i < ack_delay; i++) begin
                    @(posedge clk); #1;
                    if (rst) begin mon_abort = 1'b1; break; end
                    chk("m_stb_hold", mem.stb, 1);
                end
                if (!mon_abort) begin
                    mem.dat_r = mem_rdata;
                    mem.ack = 1'b1;
                    @(posedge clk); #1;
                    mem.ack = 1'b0;
                    chk("m_cyc_drop", mem.cyc, 0);
                    @(posedge clk); #1;
                    chk("m_gap", mem.cyc, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
        cpu.addr = '0; cpu.dat_w = '0; cpu.sel = '0; cpu.cti = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", cpu.ack, 0);
        chk("rst_cyc", mem.cyc, 0);
        chk("rst_stb", mem.stb, 0);
        chk("rst_level", buf_level, 0);
        chk("rst_empty", buf_empty, 1);
        chk("rst_dat", cpu.dat_r, 0);
        rst = 1'b0;
        init = 1'b1;

        // Single write passes straight through
        cpu_write(26'h0000100, 32'hDEADBEEF, 4'hF, lat);
        chk("t1_lat", lat, 1);
        chk("t1_level", buf_level, 1);
        wait_drain("t1");

        // Fill while the controller is not ready, fifth write stalls
        init = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(26'h200 + 26'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, lat);
            chk("t2_lat", lat, 1);
        end
        chk("t2_level", buf_level, 4);
        fork
            cpu_write(26'h210, 32'hA000_0004, 4'h5, lat5);
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("t2_full_noack", cpu.ack, 0);
                chk("t2_full_level", buf_level, 4);
                init = 1'b1;
            end
        join
        chk("t2_stall_lat", lat5, 8);
        wait_drain("t2");

        // Read waits behind two buffered writes
        init = 1'b0;
        cpu_write(26'h300, 32'h1111_1111, 4'h3, lat);
        cpu_write(26'h304, 32'h2222_2222, 4'hC, lat);
        mem_rdata = 32'h12345678;
        init = 1'b1;
        cpu_read(26'h0000100, 4'hF, rd, lat);
        chk("t3_rdata", rd, 32'h12345678);
        wait_drain("t3");
        chk("t3_dat_hold", cpu.dat_r, 32'h12345678);

        // Push in the same cycle as a pop, then more writes to wrap the pointers
        init = 1'b0;
        cpu_write(26'h400, 32'hB000_0000, 4'hF, lat);
        cpu_write(26'h404, 32'hB000_0001, 4'hF, lat);
        chk("t4_level", buf_level, 2);
        ack_delay = 2;
        init = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            if (mem.ack) break;
        end
        chk("t4_saw_ack", mem.ack, 1);
        cpu_write(26'h408, 32'hB000_0002, 4'hF, lat);
        chk("t4_pp_lat", lat, 1);
        chk("t4_pp_level", buf_level, 2);
        for (int i = 3; i < 6; i++) cpu_write(26'h400 + 26'(i * 4), 32'hB000_0000 + 32'(i), 4'h9, lat);
        wait_drain("t4");

        // Reset while a write waits for its ack
        ack_delay = 0;
        init = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(26'h500 + 26'(i * 4), 32'hC000_0000 + 32'(i), 4'hF, lat);
        chk("t5_level", buf_level, 3);
        ack_delay = 1000;
        init = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            if (mem.cyc) break;
        end
        chk("t5_in_wr", mem.cyc, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_cyc", mem.cyc, 0);
        chk("t5_stb", mem.stb, 0);
        chk("t5_level0", buf_level, 0);
        chk("t5_empty", buf_empty, 1);
        chk("t5_ack", cpu.ack, 0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ack_delay = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_discard_cyc", mem.cyc, 0);
        chk("t5_discard_empty", buf_empty, 1);

        // Slow read: strobe held 10 cycles, ack at K+2, gap before the next write
        ack_delay = 10;
        mem_rdata = 32'hCAFEF00D;
        cpu_read(26'h600, 4'h3, rd, lat);
        chk("t6_lat", lat, 12);
        chk("t6_rdata", rd, 32'hCAFEF00D);
        ack_delay = 0;
        cpu_write(26'h604, 32'h0BAD_CAFE, 4'h1, lat);
        chk("t6_wr_lat", lat, 1);
        wait_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
